// File: rtl/oqpsk_dac_spi_out.sv
// Sample-rate pacer and serial DAC driver for the OQPSK modulator output.
// A period counter requests one I sample per RATE_DIV clocks. The sample is
// captured SAMPLE_LAT edges after the request is seen, then shifted out
// MSB first as a {DAC_CMD, data} frame on CS_N/SCLK/MOSI.
//
// Request protocol: REQ_SAMPLE is a one-clock pulse with no ready/ack path.
// The modulator must present the matching I_IN sample so that it is valid on
// the edge SAMPLE_LAT clocks after the edge that samples REQ_SAMPLE high. A
// period tick that arrives while a frame is still in flight is dropped, and
// the sticky OVERRUN flag records it.
module oqpsk_dac_spi_out #(
  parameter int          SAMPLE_W   = 12,
  parameter int          DIV_W      = 16,
  parameter int          SAMPLE_LAT = 1,
  parameter int          SCLK_DIV   = 2,
  parameter logic [3:0]  DAC_CMD    = 4'b0011,
  parameter bit          OFFSET_BIN = 1'b1
) (
  input  logic                ACK,
  input  logic                RST,
  input  logic                EN,
  input  logic [DIV_W-1:0]    RATE_DIV,
  input  logic [SAMPLE_W-1:0] I_IN,
  output logic                REQ_SAMPLE,
  output logic                DAC_CS_N,
  output logic                DAC_SCLK,
  output logic                DAC_MOSI,
  output logic                BUSY,
  output logic                FRAME_DONE,
  output logic                OVERRUN,
  output logic [1:0]          dbg_state
);

  localparam int FRAME_W = 4 + SAMPLE_W;
  // One count per SCLK half period, so two per frame bit.
  localparam int HALF_W  = $clog2(2 * FRAME_W);
  // The shared counter times the capture latency, the SCLK half period
  // and the CS hold time; size it for the largest of those.
  localparam int CNT_MAX = (SAMPLE_LAT > 2 * SCLK_DIV) ? SAMPLE_LAT : 2 * SCLK_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]    LAT_C      = CNT_W'(SAMPLE_LAT);
  localparam logic [CNT_W-1:0]    DIV_LAST   = CNT_W'(SCLK_DIV - 1);
  localparam logic [CNT_W-1:0]    HOLD_LAST  = CNT_W'(2 * SCLK_DIV - 1);
  localparam logic [HALF_W-1:0]   HALF_LAST  = HALF_W'(2 * FRAME_W - 1);
  localparam logic [SAMPLE_W-1:0] SIGN_FLIP  = {1'b1, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SHIFT = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // Period counter
  logic [DIV_W-1:0] per_cnt_q, per_cnt_d;
  logic [DIV_W-1:0] per_len_q, per_len_d;
  logic [DIV_W-1:0] per_len_eff;
  logic             tick;

  // Frame FSM
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HALF_W-1:0]   half_q, half_d;
  logic [FRAME_W-2:0]  shift_q, shift_d;
  logic [SAMPLE_W-1:0] data;
  logic [FRAME_W-1:0]  frame;

  // Registered outputs
  logic req_q, req_d;
  logic cs_n_q, cs_n_d;
  logic sclk_q, sclk_d;
  logic mosi_q, mosi_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic ovr_q, ovr_d;

  // Period counter: the length is latched at the start of each period so a
  // RATE_DIV change only applies from the next wrap. 0 and 1 tick every clock.
  always_comb begin
    per_len_eff = (per_cnt_q == '0) ? RATE_DIV : per_len_q;
    per_len_d   = per_len_eff;
    per_cnt_d   = '0;
    tick        = 1'b0;
    if (EN) begin
      if ((per_len_eff <= DIV_W'(1)) || (per_cnt_q == per_len_eff - DIV_W'(1))) begin
        tick = 1'b1;
      end else begin
        per_cnt_d = per_cnt_q + DIV_W'(1);
      end
    end
  end

  // Frame word seen by the DAC: command nibble over the (optionally
  // offset-binary) sample.
  always_comb begin
    data  = OFFSET_BIN ? (I_IN ^ SIGN_FLIP) : I_IN;
    frame = {DAC_CMD, data};
  end

  // Next-state logic for the frame FSM and its registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    shift_d = shift_q;
    req_d   = 1'b0;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;
    // A tick that finds the FSM busy (including on its last CS_HOLD edge)
    // is lost; remember that until reset.
    ovr_d   = ovr_q | (tick && (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // cnt_q counts edges since the first edge that saw REQ_SAMPLE high.
        if (cnt_q == LAT_C) begin
          shift_d = frame[FRAME_W-2:0];
          mosi_d  = frame[FRAME_W-1];
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          cnt_d   = '0;
          half_d  = '0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d  = '0;
          half_d = half_q + HALF_W'(1);
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (half_q == HALF_LAST) begin
            // End of the last high phase: release the DAC.
            sclk_d  = 1'b0;
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_HOLD;
          end else begin
            // Falling SCLK: present the next bit for the next rising edge.
            sclk_d  = 1'b0;
            mosi_d  = shift_q[FRAME_W-2];
            shift_d = {shift_q[FRAME_W-3:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any frame at once.
  always_ff @(posedge ACK) begin
    if (RST) begin
      per_cnt_q <= '0;
      per_len_q <= '0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      half_q    <= '0;
      shift_q   <= '0;
      req_q     <= 1'b0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      per_cnt_q <= per_cnt_d;
      per_len_q <= per_len_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      shift_q   <= shift_d;
      req_q     <= req_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
    end
  end

  assign REQ_SAMPLE = req_q;
  assign DAC_CS_N   = cs_n_q;
  assign DAC_SCLK   = sclk_q;
  assign DAC_MOSI   = mosi_q;
  assign BUSY       = busy_q;
  assign FRAME_DONE = done_q;
  assign OVERRUN    = ovr_q;
  assign dbg_state  = state_q;

endmodule
